// File: rtl/pwm_capture_if.sv
// Signal bundle between a PWM source and the pwm_capture block; the duty output
// is present only when PWM_CAPTURE_DUTY_EN is defined.
interface pwm_capture_if #(
  parameter int CNT_W = 16
);
  logic             i_pwm;
  logic             i_enable;
  logic [CNT_W-1:0] o_period;
  logic [CNT_W-1:0] o_high;
  logic             o_valid;
  logic             o_timeout;
  logic             o_level;
`ifdef PWM_CAPTURE_DUTY_EN
  logic [6:0]       o_duty_pct;

  modport master (
    output i_pwm, i_enable,
    input  o_period, o_high, o_valid, o_timeout, o_level, o_duty_pct
  );
  modport slave (
    input  i_pwm, i_enable,
    output o_period, o_high, o_valid, o_timeout, o_level, o_duty_pct
  );
`else
  modport master (
    output i_pwm, i_enable,
    input  o_period, o_high, o_valid, o_timeout, o_level
  );
  modport slave (
    input  i_pwm, i_enable,
    output o_period, o_high, o_valid, o_timeout, o_level
  );
`endif
endinterface

// File: rtl/pwm_capture.sv
// PWM period/high-time meter; PWM_CAPTURE_DUTY_EN adds a duty-cycle divider (+CNT_W+7 cycles).
// Result strobe SYNC_STAGES+1 edges after the synchronised rise; no backpressure, results are strobed.
module pwm_capture #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  pwm_capture_if.slave  bus
);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [1:0]       S_IDLE    = 2'd0;
  localparam logic [1:0]       S_MEASURE = 2'd1;
`ifdef PWM_CAPTURE_DUTY_EN
  localparam logic [1:0]       S_DIVIDE  = 2'd2;
  localparam int               DIV_N     = CNT_W + 7;
  localparam int               DIVC_W    = $clog2(DIV_N);
  localparam logic [DIV_N-1:0] HUNDRED   = DIV_N'(100);
`endif

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   sync, rise, fall, track_fall;
  logic [1:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       high_lat_q, high_lat_d;
  logic [CNT_W-1:0]       period_q, period_d;
  logic [CNT_W-1:0]       high_q, high_d;
  logic                   valid_q, valid_d;
  logic                   timeout_q, timeout_d;
`ifdef PWM_CAPTURE_DUTY_EN
  logic [DIVC_W-1:0]      div_cnt_q, div_cnt_d;
  logic [DIV_N-1:0]       dvd_q, dvd_d;
  logic [CNT_W-1:0]       rem_q, rem_d;
  logic [CNT_W-1:0]       pper_q, pper_d;
  logic [CNT_W-1:0]       phigh_q, phigh_d;
  logic [6:0]             duty_q, duty_d;
  logic [DIV_N-1:0]       prod, quo_nxt;
  logic [CNT_W:0]         shifted;
  logic                   ge;
`endif

  assign sync = sync_q[SYNC_STAGES-1];
  assign rise = sync & ~prev_q;
  assign fall = ~sync & prev_q;

`ifdef PWM_CAPTURE_DUTY_EN
  // A short high phase can end while the previous result is still dividing.
  assign track_fall = (state_q == S_MEASURE) || (state_q == S_DIVIDE);

  // Restoring divider: dvd_q shifts dividend bits out the top and quotient bits in the bottom.
  assign prod    = {7'd0, high_lat_q} * HUNDRED;
  assign shifted = {rem_q, dvd_q[DIV_N-1]};
  assign ge      = shifted >= {1'b0, pper_q};
  assign quo_nxt = {dvd_q[DIV_N-2:0], ge};
`else
  assign track_fall = (state_q == S_MEASURE);
`endif

  always_comb begin
    state_d    = state_q;
    high_lat_d = high_lat_q;
    period_d   = period_q;
    high_d     = high_q;
    valid_d    = 1'b0;
    timeout_d  = timeout_q;
    cnt_d      = cnt_q;
`ifdef PWM_CAPTURE_DUTY_EN
    div_cnt_d  = div_cnt_q;
    dvd_d      = dvd_q;
    rem_d      = rem_q;
    pper_d     = pper_q;
    phigh_d    = phigh_q;
    duty_d     = duty_q;
`endif

    if (rise) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (fall && track_fall) begin
      high_lat_d = cnt_q;
    end

    if (!bus.i_enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rise) state_d = S_MEASURE;
        end
        S_MEASURE: begin
          // A rise in the saturation cycle still closes a valid period.
          if (rise) begin
`ifdef PWM_CAPTURE_DUTY_EN
            pper_d    = cnt_q;
            phigh_d   = high_lat_q;
            dvd_d     = prod;
            rem_d     = '0;
            div_cnt_d = '0;
            state_d   = S_DIVIDE;
`else
            period_d  = cnt_q;
            high_d    = high_lat_q;
            valid_d   = 1'b1;
            timeout_d = 1'b0;
`endif
          end else if (cnt_q == CNT_MAX) begin
            timeout_d = 1'b1;
            state_d   = S_IDLE;
          end
        end
`ifdef PWM_CAPTURE_DUTY_EN
        S_DIVIDE: begin
          rem_d     = ge ? CNT_W'(shifted - {1'b0, pper_q}) : shifted[CNT_W-1:0];
          dvd_d     = quo_nxt;
          div_cnt_d = div_cnt_q + DIVC_W'(1);
          if (div_cnt_q == DIVC_W'(DIV_N - 1)) begin
            period_d  = pper_q;
            high_d    = phigh_q;
            duty_d    = quo_nxt[6:0];
            valid_d   = 1'b1;
            timeout_d = 1'b0;
            state_d   = S_MEASURE;
          end
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= '0;
      prev_q     <= 1'b0;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      high_lat_q <= '0;
      period_q   <= '0;
      high_q     <= '0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
`ifdef PWM_CAPTURE_DUTY_EN
      div_cnt_q  <= '0;
      dvd_q      <= '0;
      rem_q      <= '0;
      pper_q     <= '0;
      phigh_q    <= '0;
      duty_q     <= '0;
`endif
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], bus.i_pwm};
      prev_q     <= sync;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      high_lat_q <= high_lat_d;
      period_q   <= period_d;
      high_q     <= high_d;
      valid_q    <= valid_d;
      timeout_q  <= timeout_d;
`ifdef PWM_CAPTURE_DUTY_EN
      div_cnt_q  <= div_cnt_d;
      dvd_q      <= dvd_d;
      rem_q      <= rem_d;
      pper_q     <= pper_d;
      phigh_q    <= phigh_d;
      duty_q     <= duty_d;
`endif
    end
  end

  assign bus.o_period  = period_q;
  assign bus.o_high    = high_q;
  assign bus.o_valid   = valid_q;
  assign bus.o_timeout = timeout_q;
  assign bus.o_level   = sync;
`ifdef PWM_CAPTURE_DUTY_EN
  assign bus.o_duty_pct = duty_q;
`endif

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: each closed period queues its expected result,
// a negedge monitor pops and compares on every o_valid.
`timescale 1ns/1ps
module tb_pwm_capture;
  localparam int CNT_W       = 16;
  localparam int SYNC_STAGES = 2;
`ifdef PWM_CAPTURE_DUTY_EN
  localparam int DIV_LAT = CNT_W + 7;
`else
  localparam int DIV_LAT = 0;
`endif

  typedef struct {
    int p;
    int h;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pwm_capture_if #(.CNT_W(CNT_W)) bus ();

  pwm_capture #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  exp_t sb_q[$];
  exp_t mon_e;
  int   errors    = 0;
  int   checks    = 0;
  int   valid_cnt = 0;
  bit   armed     = 1'b0;
  int   prev_p    = 0;
  int   prev_h    = 0;

  always @(negedge clk) begin
    if (bus.o_valid === 1'b1) begin
      valid_cnt++;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got o_valid=1 (period=%0d high=%0d), required no result",
                 bus.o_period, bus.o_high);
      end else begin
        mon_e = sb_q.pop_front();
        checks++;
        if (bus.o_period !== CNT_W'(mon_e.p)) begin
          errors++;
          $display("FAIL period: got %0d, required %0d", bus.o_period, mon_e.p);
        end
        checks++;
        if (bus.o_high !== CNT_W'(mon_e.h)) begin
          errors++;
          $display("FAIL high: got %0d, required %0d", bus.o_high, mon_e.h);
        end
`ifdef PWM_CAPTURE_DUTY_EN
        checks++;
        if (bus.o_duty_pct !== 7'((mon_e.h * 100) / mon_e.p)) begin
          errors++;
          $display("FAIL duty: got %0d, required %0d", bus.o_duty_pct, (mon_e.h * 100) / mon_e.p);
        end
`endif
      end
    end
  end

  // Drives a rising edge; when enabled it closes the running period into the scoreboard.
  task automatic drive_rise;
    exp_t e;
    @(negedge clk);
    bus.i_pwm = 1'b1;
    if (bus.i_enable) begin
      if (armed) begin
        e.p = prev_p;
        e.h = prev_h;
        sb_q.push_back(e);
      end
      armed = 1'b1;
    end
  endtask

  task automatic pwm_cycle(input int p, input int h);
    drive_rise();
    prev_p = p;
    prev_h = h;
    repeat (h - 1) @(negedge clk);
    @(negedge clk);
    bus.i_pwm = 1'b0;
    repeat (p - h - 1) @(negedge clk);
  endtask

  task automatic test_reset;
    rst          = 1'b1;
    bus.i_pwm    = 1'b0;
    bus.i_enable = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.o_period, bus.o_high, bus.o_valid, bus.o_timeout, bus.o_level} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got period=%0d high=%0d valid=%b timeout=%b level=%b, required all 0",
               bus.o_period, bus.o_high, bus.o_valid, bus.o_timeout, bus.o_level);
    end
    rst   = 1'b0;
    armed = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_5khz;
    int v0;
    v0 = valid_cnt;
    repeat (3) pwm_cycle(2400, 600);
    checks++;
    if (valid_cnt - v0 != 2) begin
      errors++;
      $display("FAIL 5khz_count: got %0d results, required 2", valid_cnt - v0);
    end
  endtask

  task automatic test_rate_change;
    int v0;
    v0 = valid_cnt;
    repeat (3) pwm_cycle(1200, 600);
    checks++;
    if (valid_cnt - v0 != 3 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL change_count: got %0d results (%0d pending), required 3 (0)", valid_cnt - v0, sb_q.size());
    end
  endtask

  task automatic test_timeout;
    int n;
    int v0;
    drive_rise();
    v0 = valid_cnt;
    n  = 0;
    while (n < 70000 && bus.o_timeout !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.o_timeout !== 1'b1 || n != (1 << CNT_W) - 1 + SYNC_STAGES + 1) begin
      errors++;
      $display("FAIL timeout_time: got timeout=%b after %0d cycles, required 1 after %0d",
               bus.o_timeout, n, (1 << CNT_W) - 1 + SYNC_STAGES + 1);
    end
    checks++;
    if (bus.o_level !== 1'b1 || bus.o_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_level: got level=%b valid=%b, required level=1 valid=0", bus.o_level, bus.o_valid);
    end
    checks++;
    if (valid_cnt - v0 != 1) begin
      errors++;
      $display("FAIL timeout_results: got %0d results after hold, required 1 (closing period only)", valid_cnt - v0);
    end
    armed = 1'b0;
    @(negedge clk);
    bus.i_pwm = 1'b0;
    repeat (10) @(negedge clk);
    pwm_cycle(1200, 600);
    checks++;
    if (bus.o_timeout !== 1'b1 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL timeout_sticky: got timeout=%b pending=%0d after arming rise, required 1 and 0",
               bus.o_timeout, sb_q.size());
    end
    pwm_cycle(1200, 600);
    checks++;
    if (bus.o_timeout !== 1'b0 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL timeout_clear: got timeout=%b pending=%0d, required 0 and 0", bus.o_timeout, sb_q.size());
    end
  endtask

  task automatic test_mid_reset;
    drive_rise();
    prev_p = 1200;
    prev_h = 600;
    repeat (599) @(negedge clk);
    @(negedge clk);
    bus.i_pwm = 1'b0;
    repeat (300) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({bus.o_period, bus.o_high, bus.o_valid, bus.o_timeout, bus.o_level} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got period=%0d high=%0d valid=%b timeout=%b level=%b, required all 0",
               bus.o_period, bus.o_high, bus.o_valid, bus.o_timeout, bus.o_level);
    end
    armed = 1'b0;
    repeat (298) @(negedge clk);
    repeat (2) pwm_cycle(1200, 600);
    checks++;
    if (sb_q.size() != 0 || bus.o_period !== CNT_W'(1200)) begin
      errors++;
      $display("FAIL midreset_result: got pending=%0d period=%0d, required 0 and 1200", sb_q.size(), bus.o_period);
    end
  endtask

  task automatic test_enable_minperiod;
    int v0;
    @(negedge clk);
    bus.i_enable = 1'b0;
    armed        = 1'b0;
    v0           = valid_cnt;
    repeat (2) pwm_cycle(40, 20);
    checks++;
    if (valid_cnt != v0 || bus.o_period !== CNT_W'(1200) || bus.o_high !== CNT_W'(600)) begin
      errors++;
      $display("FAIL disable_hold: got %0d results period=%0d high=%0d, required 0 results 1200/600",
               valid_cnt - v0, bus.o_period, bus.o_high);
    end
    @(negedge clk);
    bus.i_enable = 1'b1;
    repeat (2) pwm_cycle(40, 20);
`ifndef PWM_CAPTURE_DUTY_EN
    repeat (4) pwm_cycle(2, 1);
`endif
    pwm_cycle(40, 20);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL enable_drain: got %0d pending results, required 0", sb_q.size());
    end
  endtask

  task automatic test_latency;
    pwm_cycle(80, 40);
    drive_rise();
    prev_p = 80;
    prev_h = 40;
    for (int e = 1; e <= SYNC_STAGES + 2 + DIV_LAT; e++) begin
      @(negedge clk);
      checks++;
      if (bus.o_valid !== (e == SYNC_STAGES + 1 + DIV_LAT)) begin
        errors++;
        $display("FAIL latency_edge%0d: got o_valid=%b, required %b", e, bus.o_valid,
                 (e == SYNC_STAGES + 1 + DIV_LAT));
      end
    end
    repeat (40 - (SYNC_STAGES + 2 + DIV_LAT) - 1) @(negedge clk);
    @(negedge clk);
    bus.i_pwm = 1'b0;
    repeat (39) @(negedge clk);
  endtask

  task automatic test_duty;
    pwm_cycle(2400, 1800);
    pwm_cycle(80, 40);
    checks++;
    if (sb_q.size() != 0 || bus.o_period !== CNT_W'(2400) || bus.o_high !== CNT_W'(1800)) begin
      errors++;
      $display("FAIL duty_result: got pending=%0d period=%0d high=%0d, required 0 2400/1800",
               sb_q.size(), bus.o_period, bus.o_high);
    end
`ifdef PWM_CAPTURE_DUTY_EN
    checks++;
    if (bus.o_duty_pct !== 7'd75) begin
      errors++;
      $display("FAIL duty_75: got %0d, required 75", bus.o_duty_pct);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_5khz();
    test_rate_change();
    test_timeout();
    test_mid_reset();
    test_enable_minperiod();
    test_latency();
    test_duty();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Receive-side counterpart of the board's pwm generator: measures period and high time of an incoming PWM/square-wave signal in clk cycles.
- Sits between a board input (PMOD pin or loop-back of a pwm output) and status logic such as LEDs or UART reporting.
- Drives a per-period result strobe and a timeout flag for stuck-high or stuck-low inputs.

Parameters:
- CNT_W, 16: width of the period/high counters and result outputs; saturation value is 2**CNT_W-1.
- SYNC_STAGES, 2: number of input synchroniser flops; legal values are 2 or 3.

Ports:
- clk  input  1  system clock (12 MHz on board)
- rst  input  1  synchronous reset, active-high
- i_pwm  input  1  asynchronous PWM input
- i_enable  input  1  1 = measure; 0 = hold outputs, return to IDLE
- o_period  output  CNT_W  clk cycles between consecutive rising edges
- o_high  output  CNT_W  clk cycles from rising edge to following falling edge
- o_valid  output  1  one-cycle strobe; o_period and o_high are updated in the same cycle
- o_timeout  output  1  sticky flag: no edge seen for 2**CNT_W-1 cycles
- o_level  output  1  synchronised input level

Behaviour:
- Reset, applied at any time including mid-measurement: all outputs 0, state IDLE, counter 0, synchroniser flops 0.
- Synchroniser: i_pwm passes through SYNC_STAGES flops, then one extra flop (prev).
  - rise = sync & ~prev; fall = ~sync & prev. Both are combinational from registers.
  - o_level = sync.
- Counter cnt:
  - On a rise cycle: cnt <= 1.
  - Otherwise: cnt <= cnt + 1, saturating at 2**CNT_W-1. It never wraps.
- Falling edge: on a fall cycle in state MEASURE, high_lat <= cnt.
- States:
  - IDLE: wait for rise; on rise go to MEASURE. No o_valid issued.
  - MEASURE, on rise:
    - o_period <= cnt; o_high <= high_lat; o_valid <= 1 for one cycle.
    - o_timeout <= 0; stay in MEASURE.
    - With P cycles between rises and H high cycles, results are exactly P and H.
  - MEASURE, cnt reaches saturation with no rise: o_timeout <= 1, go to IDLE. o_period and o_high hold their last values.
  - i_enable = 0 in any state: go to IDLE next cycle. cnt keeps running; outputs hold; o_valid forced 0.
- Latency:
  - Count the clk edge that first samples i_pwm high as edge 1.
  - With SYNC_STAGES=2, o_valid is high after edge 3.
  - Latency is fixed; each extra sync stage adds 1.
- Boundaries:
  - First rise after reset, enable or timeout only arms the block; the first o_valid comes on the second rise.
  - 0% or 100% duty: handled as timeout; o_level distinguishes stuck-low from stuck-high.
  - Period >= 2**CNT_W-1: timeout, no result.
  - Minimum measurable period is 2 cycles (H=1, P=2).
  - A rise and the saturation condition in the same cycle: the rise wins and a result is issued.
  - o_timeout holds until the next o_valid.

Optional Feature:
- Macro: PWM_CAPTURE_DUTY_EN.
- When defined:
  - Adds port o_duty_pct, output, 7 bits: floor(high*100/period).
  - Adds state DIVIDE: an iterative restoring divider of (o_high*100) by o_period, one quotient bit per cycle, CNT_W+7 cycles.
  - o_valid is delayed until the division completes. o_period, o_high and o_duty_pct all update in that same cycle.
  - A rise during DIVIDE restarts cnt normally. The period that ends on that rise is dropped (no o_valid), and the block returns to MEASURE after the divide.
  - Periods of at least CNT_W+8 cycles produce a result every period.
- When undefined: no o_duty_pct port and no DIVIDE state; latency as stated above.

Test Plan:
- Reset, then 5 kHz PWM (P=2400, H=600): no o_valid on the first rise; from the second rise on, o_valid every 2400 cycles with o_period=2400 and o_high=600.
- Change to P=1200, H=600 mid-stream: the first result after the change carries the transition period; all subsequent results read 1200/600.
- Hold i_pwm high after a valid run: o_timeout=1 and o_level=1 about 65535 cycles after the last rise, no o_valid. Resume toggling: o_valid on the second rise, o_timeout cleared.
- Assert rst for 1 cycle mid-period: all outputs 0 the next cycle; the first rise after reset gives no o_valid.
- Single isolated rise with SYNC_STAGES=2, measuring from the second rise: o_valid high exactly after edge 3; o_valid width is 1 cycle.
- With PWM_CAPTURE_DUTY_EN defined, P=2400, H=1800: o_duty_pct=75; o_valid occurs CNT_W+7 cycles later than without the macro.
